// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use hazard detection.
// Inserts bubbles on stall or flush and tracks saturating event counts.
module id_ex_stage #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    input  logic [8:0]       ctrl_in,
    input  logic [4:0]       ext_in,
    input  logic [31:0]      pc4_in,
    input  logic [31:0]      rd1_in,
    input  logic [31:0]      rd2_in,
    input  logic [31:0]      imm_in,
    input  logic [4:0]       rs_in,
    input  logic [4:0]       rt_in,
    input  logic [4:0]       rd_in,
    input  logic             flush,
    output logic             stall_o,
    output logic             ex_valid,
    output logic [8:0]       ex_ctrl,
    output logic [4:0]       ex_ext,
    output logic [31:0]      ex_pc4,
    output logic [31:0]      ex_rd1,
    output logic [31:0]      ex_rd2,
    output logic [31:0]      ex_imm,
    output logic [4:0]       ex_rs,
    output logic [4:0]       ex_rt,
    output logic [4:0]       ex_rd,
    output logic [CNT_W-1:0] stall_count,
    output logic [CNT_W-1:0] flush_count
);

    logic             r_valid;
    logic [8:0]       r_ctrl;
    logic [4:0]       r_ext;
    logic [31:0]      r_pc4;
    logic [31:0]      r_rd1;
    logic [31:0]      r_rd2;
    logic [31:0]      r_imm;
    logic [4:0]       r_rs;
    logic [4:0]       r_rt;
    logic [4:0]       r_rd;
    logic [CNT_W-1:0] r_stall_cnt;
    logic [CNT_W-1:0] r_flush_cnt;

    logic w_uses_rt;
    logic w_rt_hit;
    logic w_hazard;

    // rt is a source only for R-type, sw, beq and bne
    assign w_uses_rt = ctrl_in[1] | ctrl_in[4] | ctrl_in[0] | ext_in[3];
    assign w_rt_hit  = (r_rt == rs_in) | (w_uses_rt & (r_rt == rt_in));
    assign w_hazard  = in_valid & r_valid & r_ctrl[5]
                     & (r_rt != 5'd0) & w_rt_hit;
    assign stall_o   = w_hazard & ~flush;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_valid     <= 1'b0;
            r_ctrl      <= '0;
            r_ext       <= '0;
            r_pc4       <= '0;
            r_rd1       <= '0;
            r_rd2       <= '0;
            r_imm       <= '0;
            r_rs        <= '0;
            r_rt        <= '0;
            r_rd        <= '0;
            r_stall_cnt <= '0;
            r_flush_cnt <= '0;
        end else begin
            // data fields load even during a bubble so ex_rt tracks the stalled op
            r_pc4 <= pc4_in;
            r_rd1 <= rd1_in;
            r_rd2 <= rd2_in;
            r_imm <= imm_in;
            r_rs  <= rs_in;
            r_rt  <= rt_in;
            r_rd  <= rd_in;
            if (flush) begin
                r_valid <= 1'b0;
                r_ctrl  <= '0;
                r_ext   <= '0;
                if (in_valid && (r_flush_cnt != '1))
                    r_flush_cnt <= r_flush_cnt + 1'b1;
            end else if (w_hazard) begin
                r_valid <= 1'b0;
                r_ctrl  <= '0;
                r_ext   <= '0;
                if (r_stall_cnt != '1)
                    r_stall_cnt <= r_stall_cnt + 1'b1;
            end else begin
                r_valid <= in_valid;
                r_ctrl  <= in_valid ? ctrl_in : 9'd0;
                r_ext   <= in_valid ? ext_in : 5'd0;
            end
        end
    end

    assign ex_valid    = r_valid;
    assign ex_ctrl     = r_ctrl;
    assign ex_ext      = r_ext;
    assign ex_pc4      = r_pc4;
    assign ex_rd1      = r_rd1;
    assign ex_rd2      = r_rd2;
    assign ex_imm      = r_imm;
    assign ex_rs       = r_rs;
    assign ex_rt       = r_rt;
    assign ex_rd       = r_rd;
    assign stall_count = r_stall_cnt;
    assign flush_count = r_flush_cnt;

endmodule

// File: doc/id_ex_stage.md
# id_ex_stage

ID/EX pipeline register with load-use hazard detection, sitting directly downstream of the decode control unit. Each cycle it captures the 9-bit control word, the five extended decode flags and the decoded operands, and presents them to the execute stage one cycle later. On a load-use hazard it inserts a bubble and requests an IF/ID stall; on a branch/jump flush it inserts a bubble. It also keeps saturating stall and flush counters for performance monitoring.

## Interface
- CNT_W, 16, width of the stall and flush counters
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-high
- in_valid  in  1  IF/ID holds a real instruction
- ctrl_in  in  9  control word: [8] memtoreg, [7] regwrite, [6] branch, [5] memread, [4] memwrite, [3] regdst, [2] alusrc, [1] rtype, [0] beq
- ext_in  in  5  {j, bne, andi, ori, addi}
- pc4_in, rd1_in, rd2_in, imm_in  in  32 each  PC+4, register reads, sign-extended immediate
- rs_in, rt_in, rd_in  in  5 each  register specifiers
- flush  in  1  branch/jump taken; squash the instruction entering this stage
- stall_o  out  1  combinational; hold PC and IF/ID this cycle
- ex_valid  out  1  registered valid
- ex_ctrl  out  9  registered control word, same layout as ctrl_in
- ex_ext  out  5  registered extended flags
- ex_pc4, ex_rd1, ex_rd2, ex_imm  out  32 each  registered data
- ex_rs, ex_rt, ex_rd  out  5 each  registered specifiers
- stall_count, flush_count  out  CNT_W each  saturating event counters

## Operation
- uses_rt = ctrl_in[1] | ctrl_in[4] | ctrl_in[0] | ext_in[3] (R-type, sw, beq, bne).
- hazard = in_valid & ex_valid & ex_ctrl[5] & (ex_rt != 0) & ((ex_rt == rs_in) | (uses_rt & (ex_rt == rt_in))).
- stall_o = hazard & ~flush.
- Register update priority per rising edge:
  - reset: every output register and both counters go to 0.
  - flush: bubble. ex_valid, ex_ctrl and ex_ext go to 0; data and specifier fields load normally. flush_count increments if in_valid is 1.
  - hazard (no flush): bubble as above. stall_count increments.
  - otherwise: all fields load from the inputs. ex_valid = in_valid. ex_ctrl and ex_ext are forced to 0 when in_valid is 0.
- Counters saturate at 2^CNT_W-1 and never wrap.
- A bubble always has all control bits 0, so it performs no register write, memory access or branch.
- Because data fields load during a bubble, ex_rt takes the stalled instruction's rt. The hazard therefore clears after exactly one bubble, since ex_ctrl[5] is 0 on the following cycle.

## Timing
- Input-to-ex_* latency is 1 cycle.
- stall_o is combinational from the current inputs and registered ex_* state, with no added latency. It is valid within the same cycle.
- A load-use pair costs exactly one bubble cycle. stall_o is high for 1 cycle and the dependent instruction enters ex_* one cycle later.
- Back-to-back lw chains each produce an independent one-cycle stall.
- flush and hazard in the same cycle:
  - flush wins and stall_o = 0.
  - flush_count increments and stall_count does not.
- reset asserted mid-stall or mid-flush:
  - The next edge clears all state. stall_o falls in that same cycle, because ex_valid drops to 0.
  - No partial update of counters occurs on a reset edge.
- While reset is high, stall_o = 0 after the first edge.
- rt = $0 never creates a hazard, even when ex_memread = 1.

## Test plan
- Reset: drive random inputs with reset = 1 for 2 cycles -> all ex_* = 0, counters = 0, stall_o = 0.
- Pass-through: in_valid=1, ctrl_in=9'b11_010_0100 (lw), pc4_in=0x104, rt_in=8 -> next cycle ex_ctrl=9'b110100100, ex_pc4=0x104, ex_rt=8, ex_valid=1, stall_o=0.
- Load-use: lw $8 in EX, then R-type with rs_in=8 presented -> stall_o=1 that cycle. Next cycle ex_valid=0, ex_ctrl=0, stall_count=1, stall_o=0. The R-type then enters on the following edge.
- No false hazards:
  - lw with rt=0 followed by rs_in=0 -> stall_o=0.
  - lw $9 followed by addi with rt_in=9 and rs_in=3 (uses_rt=0) -> stall_o=0.
- Flush priority: hazard condition plus flush=1 in the same cycle -> stall_o=0, next cycle ex_ctrl=0, flush_count=1, stall_count unchanged.
- Saturation: CNT_W=2, force 5 consecutive hazards -> stall_count reads 1, 2, 3, 3, 3. Then assert reset mid-hazard -> counter = 0 on the next edge.
